// File: rtl/mem_pkg.sv
// Shared types and helpers for the word-organised memory responder.
// Contents: FSM state enum, captured-operation enum, word width constant,
// and addr_ok(), which yields the word index and the address-fault flag.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_e;

  typedef struct packed {
    logic        err;
    logic [31:0] idx;
  } addr_chk_t;

  // Index is a 32-bit unsigned word offset from base; any of misalignment,
  // below-base or beyond-depth marks the access as faulty.
  function automatic addr_chk_t addr_ok(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned aw);
    addr_chk_t r;
    r.idx = (addr - base) >> 2;
    r.err = (addr[1:0] != 2'b00) || (addr < base) || ((r.idx >> aw) != 32'd0);
    return r;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port word RAM: synchronous write, registered (synchronous) read.
// Ports: clk, we_i (write enable), addr_i (word index), wdata_i, rdata_o
// (contents at addr_i as of the previous edge). No reset on the array.
module sp_ram #(
  parameter int AW     = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**AW];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory slave for the multicycle datapath with programmable wait states.
// Ports: MemRead/MemWrite/MemAddr/MemWData request in; MemData (held read
// data), MemReady (1-cycle strobe), MemErr (rejected access), Busy out.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          AW        = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       MemAddr,
  input  logic [WORD_W-1:0] MemWData,
  output logic [WORD_W-1:0] MemData,
  output logic              MemReady,
  output logic              MemErr,
  output logic              Busy
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("mem_responder: BASE_ADDR must be 4-byte aligned");
  end

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q;
  op_e               op_q;
  logic [3:0]        cnt_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] data_q;
  logic              ready_q, err_q, busy_q;

  // In IDLE the RAM is addressed straight from MemAddr so that its registered
  // read data is already valid one edge after accept (needed at LATENCY=1).
  // Afterwards it follows the captured address, which is what commit uses.
  logic [31:0]       ram_src;
  addr_chk_t         chk;
  logic              acc_err, commit, ram_we, unused_idx_hi;
  logic [WORD_W-1:0] ram_rdata;

  assign ram_src       = (state_q == IDLE) ? MemAddr : addr_q;
  assign chk           = addr_ok(ram_src, BASE_ADDR, AW);
  assign unused_idx_hi = ^chk.idx[31:AW];
  assign acc_err       = chk.err || (op_q == OP_ILL);
  assign commit        = (state_q == WAIT) && (cnt_q == 4'd0);
  assign ram_we        = commit && (op_q == OP_WR) && !acc_err;

  sp_ram #(.AW(AW), .WORD_W(WORD_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (chk.idx[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemRead || MemWrite) begin
            addr_q  <= MemAddr;
            wdata_q <= MemWData;
            op_q    <= (MemRead && MemWrite) ? OP_ILL : (MemWrite ? OP_WR : OP_RD);
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!acc_err && op_q == OP_RD) data_q <= ram_rdata;
            ready_q <= 1'b1;
            err_q   <= acc_err;
            state_q <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MemData  = data_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;
  assign Busy     = busy_q;

endmodule
